udp_hdr_insert: RTL and testbench
=================================

UDP_HDR_INSERT -- requirements
Module: udp_hdr_insert

Interface
REQ-001 Parameter SRC_IP, default 32'hC0A8010A, IPv4 source address.
REQ-002 Parameter DST_IP, default 32'hC0A80164, IPv4 destination address.
REQ-003 Parameter SRC_PORT, default 16'd4096, UDP source port.
REQ-004 Parameter DST_PORT, default 16'd4096, UDP destination port.
REQ-005 Parameter TTL, default 8'd64, IPv4 time-to-live.
REQ-006 clk  input  1  sole clock; all logic on posedge clk.
REQ-007 rstn  input  1  reset, asynchronous assert, active-low.
REQ-008 s_tvalid/s_tready/s_tdata[7:0]/s_tlast  input/output/input/input  payload byte stream in.
REQ-009 len_tvalid/len_tready/len_tdata[15:0]  input/output/input  per-frame length; len_tdata = payload bytes minus one.
REQ-010 m_tvalid/m_tready/m_tdata[7:0]/m_tlast  output/input/output/output  IPv4+UDP+payload stream out.

Function
REQ-011 FSM states IDLE, CSUM1, CSUM2, HDR, PAY; a single frame is processed at a time.
REQ-012 IDLE: len_tready=1, s_tready=0, m_tvalid=0; on len_tvalid&len_tready capture len_tdata and go to CSUM1.
REQ-013 tot_len = len+29, udp_len = len+9, both modulo 2^16; no clamping.
REQ-014 CSUM1: 17-bit one's-complement accumulation of all header words except checksum; CSUM2: end-around-carry fold twice, invert; go to HDR.
REQ-015 First header byte on m_tdata with m_tvalid=1 in the 3rd cycle after the length handshake.
REQ-016 HDR emits 28 bytes in order: 45 00 totlen[15:8] totlen[7:0] id[15:8] id[7:0] 40 00 TTL 11 csum[15:8] csum[7:0] SRC_IP(4, MSB first) DST_IP(4) SRC_PORT(2) DST_PORT(2) udp_len(2) 00 00.
REQ-017 HDR: m_tvalid=1, s_tready=0, m_tlast=0; the byte index advances only on m_tvalid&m_tready; after byte 27 is accepted go to PAY.
REQ-018 PAY: combinational pass-through, m_tvalid=s_tvalid, s_tready=m_tready, m_tdata=s_tdata, m_tlast=s_tlast.
REQ-019 PAY: on s_tvalid&s_tready&s_tlast go to IDLE; the next length is accepted no earlier than the following cycle.
REQ-020 Payload byte count is not checked against len; framing follows s_tlast only.
REQ-021 len_tready=0 in every state except IDLE; s_tready=0 in every state except PAY.
REQ-022 m_tvalid held with stable m_tdata until accepted (AXI-Stream rules).

Reset
REQ-023 While rstn=0: state IDLE, byte index 0, id 0, captured length 0, m_tvalid=0, m_tlast=0, m_tdata=0, s_tready=0, len_tready=0.
REQ-024 Reset asserted mid-frame abandons the frame immediately; no partial header or payload is emitted after release.
REQ-025 len_tready rises no earlier than the first clk edge after rstn deasserts.

Configuration
REQ-026 Macro UDP_HDR_IPID_EN defined: the 16-bit id increments by 1 after each frame's last header byte is accepted, wrapping FFFF->0000, and is included in the checksum.
REQ-027 UDP_HDR_IPID_EN undefined: id is constant 0000 and the id register is not built.

Structure
REQ-028 Package udp_hdr_pkg holds the state enum, the constants HDR_BYTES=28, IP_VER_IHL=8'h45, IP_PROTO_UDP=8'h11, IP_FLAGS_DF=16'h4000, and the length offsets 29 and 9.
REQ-029 One sub-module, udp_hdr_csum, holds the two-stage checksum (static sum plus tot_len and id, fold, invert).

Verification
REQ-030 Default parameters, id 0, len_tdata=99, 100-byte payload -> header bytes 2-3 = 00 80, bytes 10-11 = B6 AE, bytes 24-25 = 00 6C; 128 bytes total; m_tlast on byte 127 only.
REQ-031 m_tready toggled at random 50% during HDR and PAY -> byte sequence identical to REQ-030, with no drops or duplicates.
REQ-032 len_tdata=0, one-byte payload with s_tlast -> 29 output bytes, tot_len 001D, udp_len 0009.
REQ-033 UDP_HDR_IPID_EN defined, three back-to-back frames -> ids 0000, 0001, 0002, each frame with a correct recomputed checksum.
REQ-034 rstn pulsed low at header byte 10 -> m_tvalid=0 asynchronously; the next frame after release starts cleanly with byte 45.
REQ-035 len_tvalid held high continuously -> exactly one length accepted per frame, and only in IDLE.

Source files
------------

// File: rtl/udp_hdr_pkg.sv
// Shared types and constants for the IPv4/UDP header inserter.
// Includes the constant-fold helper for the parameter-only part of the IPv4 checksum.
package udp_hdr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CSUM1 = 3'd1,
    CSUM2 = 3'd2,
    HDR   = 3'd3,
    PAY   = 3'd4
  } state_t;

  localparam int unsigned HDR_BYTES = 28;
  localparam int unsigned IDX_W     = 5;

  localparam logic [7:0]  IP_VER_IHL   = 8'h45;
  localparam logic [7:0]  IP_PROTO_UDP = 8'h11;
  localparam logic [15:0] IP_FLAGS_DF  = 16'h4000;

  localparam logic [15:0] TOT_LEN_OFS = 16'd29;
  localparam logic [15:0] UDP_LEN_OFS = 16'd9;

  // Folded one's-complement sum of every header word that does not depend on the frame.
  function automatic logic [15:0] static_sum(input logic [31:0] src_ip,
                                             input logic [31:0] dst_ip,
                                             input logic [7:0]  ttl);
    logic [19:0] acc;
    acc = 20'({IP_VER_IHL, 8'h00}) + 20'(IP_FLAGS_DF) + 20'({ttl, IP_PROTO_UDP})
        + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
        + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
    acc = 20'(acc[15:0]) + 20'(acc[19:16]);
    acc = 20'(acc[15:0]) + 20'(acc[19:16]);
    return acc[15:0];
  endfunction

endpackage

// File: rtl/udp_hdr_csum.sv
// Two-stage IPv4 header checksum: stage 1 adds the per-frame words to the static sum,
// stage 2 folds the end-around carry twice and inverts.
module udp_hdr_csum
  import udp_hdr_pkg::*;
#(
  parameter logic [15:0] STATIC_SUM = 16'h0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_stage1,
  input  logic        i_stage2,
  input  logic [15:0] i_tot_len,
  input  logic [15:0] i_id,
  output logic [15:0] o_csum
);

  logic [16:0] w_part;
  logic [15:0] w_part_fold;
  logic [16:0] w_acc;
  logic [16:0] w_fold1;
  logic [15:0] w_fold2;
  logic [16:0] r_acc;
  logic [15:0] r_csum;

  // Carry from the first addition is wrapped before adding id so the sum stays 17 bits.
  always_comb begin
    w_part      = 17'(STATIC_SUM) + 17'(i_tot_len);
    w_part_fold = w_part[15:0] + 16'(w_part[16]);
    w_acc       = 17'(w_part_fold) + 17'(i_id);
    w_fold1     = 17'(r_acc[15:0]) + 17'(r_acc[16]);
    w_fold2     = w_fold1[15:0] + 16'(w_fold1[16]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc  <= '0;
      r_csum <= '0;
    end else begin
      if (i_stage1) r_acc  <= w_acc;
      if (i_stage2) r_csum <= ~w_fold2;
    end
  end

  assign o_csum = r_csum;

endmodule

// File: rtl/udp_hdr_insert.sv
// Prepends a 28-byte IPv4+UDP header to each payload frame, one frame at a time.
// Optional macro UDP_HDR_IPID_EN enables an incrementing IPv4 identification field.
module udp_hdr_insert
  import udp_hdr_pkg::*;
#(
  parameter logic [31:0] SRC_IP   = 32'hC0A8010A,
  parameter logic [31:0] DST_IP   = 32'hC0A80164,
  parameter logic [15:0] SRC_PORT = 16'd4096,
  parameter logic [15:0] DST_PORT = 16'd4096,
  parameter logic [7:0]  TTL      = 8'd64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s_tvalid,
  output logic        s_tready,
  input  logic [7:0]  s_tdata,
  input  logic        s_tlast,
  input  logic        len_tvalid,
  output logic        len_tready,
  input  logic [15:0] len_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic [7:0]  m_tdata,
  output logic        m_tlast
);

  state_t             r_state;
  state_t             w_next;
  logic [15:0]        r_len;
  logic [IDX_W-1:0]   r_idx;
  logic               r_len_en;
  logic [15:0]        w_id;
  logic [15:0]        w_tot_len;
  logic [15:0]        w_udp_len;
  logic [15:0]        w_csum;
  logic [7:0]         w_hdr_byte;
  logic               w_len_hs;
  logic               w_hdr_hs;
  logic               w_hdr_done;

  assign w_tot_len  = r_len + TOT_LEN_OFS;
  assign w_udp_len  = r_len + UDP_LEN_OFS;
  assign w_len_hs   = (r_state == IDLE) && r_len_en && len_tvalid;
  assign w_hdr_hs   = (r_state == HDR) && m_tready;
  assign w_hdr_done = w_hdr_hs && (r_idx == IDX_W'(HDR_BYTES - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    len_tready = 1'b0;
    s_tready   = 1'b0;
    m_tvalid   = 1'b0;
    m_tdata    = 8'h00;
    m_tlast    = 1'b0;
    case (r_state)
      IDLE: begin
        len_tready = r_len_en;
        if (w_len_hs) w_next = CSUM1;
      end
      CSUM1: w_next = CSUM2;
      CSUM2: w_next = HDR;
      HDR: begin
        m_tvalid = 1'b1;
        m_tdata  = w_hdr_byte;
        if (w_hdr_done) w_next = PAY;
      end
      PAY: begin
        m_tvalid = s_tvalid;
        s_tready = m_tready;
        m_tdata  = s_tdata;
        m_tlast  = s_tlast;
        if (s_tvalid && m_tready && s_tlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // r_len_en holds off len_tready until the first edge after reset release.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_len_en <= 1'b0;
      r_len    <= '0;
      r_idx    <= '0;
    end else begin
      r_len_en <= 1'b1;
      if (w_len_hs) r_len <= len_tdata;
      if (w_hdr_hs) r_idx <= w_hdr_done ? '0 : r_idx + IDX_W'(1);
    end
  end

`ifdef UDP_HDR_IPID_EN
  logic [15:0] r_id;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)          r_id <= '0;
    else if (w_hdr_done) r_id <= r_id + 16'd1;
  end

  assign w_id = r_id;
`else
  assign w_id = 16'h0000;
`endif

  udp_hdr_csum #(
    .STATIC_SUM (static_sum(SRC_IP, DST_IP, TTL))
  ) u_csum (
    .clk       (clk),
    .rstn      (rstn),
    .i_stage1  (r_state == CSUM1),
    .i_stage2  (r_state == CSUM2),
    .i_tot_len (w_tot_len),
    .i_id      (w_id),
    .o_csum    (w_csum)
  );

  always_comb begin
    w_hdr_byte = 8'h00;
    case (r_idx)
      5'd0:  w_hdr_byte = IP_VER_IHL;
      5'd1:  w_hdr_byte = 8'h00;
      5'd2:  w_hdr_byte = w_tot_len[15:8];
      5'd3:  w_hdr_byte = w_tot_len[7:0];
      5'd4:  w_hdr_byte = w_id[15:8];
      5'd5:  w_hdr_byte = w_id[7:0];
      5'd6:  w_hdr_byte = IP_FLAGS_DF[15:8];
      5'd7:  w_hdr_byte = IP_FLAGS_DF[7:0];
      5'd8:  w_hdr_byte = TTL;
      5'd9:  w_hdr_byte = IP_PROTO_UDP;
      5'd10: w_hdr_byte = w_csum[15:8];
      5'd11: w_hdr_byte = w_csum[7:0];
      5'd12: w_hdr_byte = SRC_IP[31:24];
      5'd13: w_hdr_byte = SRC_IP[23:16];
      5'd14: w_hdr_byte = SRC_IP[15:8];
      5'd15: w_hdr_byte = SRC_IP[7:0];
      5'd16: w_hdr_byte = DST_IP[31:24];
      5'd17: w_hdr_byte = DST_IP[23:16];
      5'd18: w_hdr_byte = DST_IP[15:8];
      5'd19: w_hdr_byte = DST_IP[7:0];
      5'd20: w_hdr_byte = SRC_PORT[15:8];
      5'd21: w_hdr_byte = SRC_PORT[7:0];
      5'd22: w_hdr_byte = DST_PORT[15:8];
      5'd23: w_hdr_byte = DST_PORT[7:0];
      5'd24: w_hdr_byte = w_udp_len[15:8];
      5'd25: w_hdr_byte = w_udp_len[7:0];
      default: w_hdr_byte = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_udp_hdr_insert.sv
// Directed self-checking bench for udp_hdr_insert (default parameters).
// Expected id follows UDP_HDR_IPID_EN when the bench is built with that macro.
module tb_udp_hdr_insert;

  logic        clk = 1'b0;
  logic        rstn;
  logic        s_tvalid, s_tready, s_tlast;
  logic [7:0]  s_tdata;
  logic        len_tvalid, len_tready;
  logic [15:0] len_tdata;
  logic        m_tvalid, m_tready, m_tlast;
  logic [7:0]  m_tdata;

  udp_hdr_insert dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .len_tvalid (len_tvalid),
    .len_tready (len_tready),
    .len_tdata  (len_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  cap_data [0:1023];
  logic        cap_last [0:1023];
  int          cap_n, len_hs, lat, stall_err;
  bit          fr_done, bad_idle;
  logic [15:0] exp_id = 16'h0000;

  function automatic logic [7:0] pay_byte(input int k);
    return 8'((k * 7 + 3) & 255);
  endfunction

  // Independent reference checksum over the nine header words.
  function automatic logic [15:0] model_csum(input logic [15:0] tot, input logic [15:0] id);
    logic [31:0] s;
    s = 32'h4500 + 32'(tot) + 32'(id) + 32'h4000 + 32'h4011
      + 32'hC0A8 + 32'h010A + 32'hC0A8 + 32'h0164;
    s = 32'(s[15:0]) + 32'(s[31:16]);
    s = 32'(s[15:0]) + 32'(s[31:16]);
    return ~s[15:0];
  endfunction

  function automatic logic [7:0] model_hdr(input logic [15:0] len_m1, input logic [15:0] id,
                                           input int i);
    logic [15:0] tot, udp, cs;
    tot = len_m1 + 16'd29;
    udp = len_m1 + 16'd9;
    cs  = model_csum(tot, id);
    case (i)
      0:  return 8'h45;   1: return 8'h00;
      2:  return tot[15:8]; 3: return tot[7:0];
      4:  return id[15:8];  5: return id[7:0];
      6:  return 8'h40;   7: return 8'h00;
      8:  return 8'd64;   9: return 8'h11;
      10: return cs[15:8]; 11: return cs[7:0];
      12: return 8'hC0;  13: return 8'hA8; 14: return 8'h01; 15: return 8'h0A;
      16: return 8'hC0;  17: return 8'hA8; 18: return 8'h01; 19: return 8'h64;
      20: return 8'h10;  21: return 8'h00; 22: return 8'h10; 23: return 8'h00;
      24: return udp[15:8]; 25: return udp[7:0];
      default: return 8'h00;
    endcase
  endfunction

  function automatic int hdr_errs(input logic [15:0] len_m1, input logic [15:0] id);
    int e = 0;
    for (int i = 0; i < 28; i++)
      if (i >= cap_n || cap_data[i] !== model_hdr(len_m1, id, i)) e++;
    return e;
  endfunction

  function automatic int pay_errs(input int pay_n);
    int e = 0;
    for (int k = 0; k < pay_n; k++)
      if (28 + k >= cap_n || cap_data[28 + k] !== pay_byte(k)) e++;
    return e;
  endfunction

  function automatic int last_errs();
    int e = 0;
    for (int i = 0; i < cap_n; i++)
      if (cap_last[i] !== 1'(i == cap_n - 1)) e++;
    return e;
  endfunction

  // Drives one frame cycle by cycle; inputs change at negedge, outputs sampled 1 unit before posedge.
  task automatic run_frame(input logic [15:0] len_m1, input int pay_n, input bit rnd,
                           input bit hold_len, input int abort_at);
    int   pidx = 0;
    int   cyc = 0;
    int   hs_cyc = -1;
    int   first_cyc = -1;
    bit   prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    cap_n = 0; len_hs = 0; lat = -1; stall_err = 0;
    fr_done = 1'b0; bad_idle = 1'b0;
    while (!fr_done && cyc < 2000) begin
      @(negedge clk);
      len_tvalid = (len_hs == 0) || hold_len;
      len_tdata  = len_m1;
      m_tready   = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      s_tvalid   = (pidx < pay_n);
      s_tdata    = pay_byte(pidx);
      s_tlast    = (pidx == pay_n - 1);
      #4;
      if (len_tvalid && len_tready) begin
        len_hs++;
        if (hs_cyc < 0) hs_cyc = cyc;
      end
      if (len_tready && (m_tvalid || s_tready)) bad_idle = 1'b1;
      if (prev_stall && (!m_tvalid || m_tdata !== prev_data)) stall_err++;
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      if (m_tvalid && hs_cyc >= 0 && first_cyc < 0) first_cyc = cyc;
      if (m_tvalid && m_tready && cap_n < 1024) begin
        cap_data[cap_n] = m_tdata;
        cap_last[cap_n] = m_tlast;
        cap_n++;
        if (m_tlast) fr_done = 1'b1;
      end
      if (s_tvalid && s_tready) pidx++;
      cyc++;
      if (abort_at >= 0 && cap_n == abort_at) break;
    end
    if (first_cyc >= 0 && hs_cyc >= 0) lat = first_cyc - hs_cyc;
  endtask

  task automatic next_id();
`ifdef UDP_HDR_IPID_EN
    exp_id = exp_id + 16'd1;
`endif
  endtask

  task automatic test_reset();
    rstn = 1'b0; s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
    len_tvalid = 1'b0; len_tdata = 16'h0000; m_tready = 1'b0;
    @(negedge clk); #1;
    n_tests++;
    if ({m_tvalid, m_tlast, s_tready, len_tready} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {m_tvalid, m_tlast, s_tready, len_tready});
    end
    n_tests++;
    if (m_tdata !== 8'h00) begin
      n_fail++; $display("FAIL reset_tdata: got %h expected 00", m_tdata);
    end
    @(negedge clk); rstn = 1'b1; #1;
    n_tests++;
    if (len_tready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_rdy: got %b expected 0", len_tready);
    end
    @(posedge clk); #1;
    n_tests++;
    if (len_tready !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_edge_rdy: got %b expected 1", len_tready);
    end
    exp_id = 16'h0000;
  endtask

  task automatic test_basic();
    run_frame(16'd99, 100, 1'b0, 1'b0, -1);
    n_tests++;
    if (fr_done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", fr_done); end
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    n_tests++;
    if (cap_n !== 128) begin n_fail++; $display("FAIL basic_count: got %0d expected 128", cap_n); end
    n_tests++;
    if ({cap_data[2], cap_data[3]} !== 16'h0080) begin
      n_fail++; $display("FAIL basic_totlen: got %h expected 0080", {cap_data[2], cap_data[3]});
    end
    n_tests++;
    if ({cap_data[10], cap_data[11]} !== 16'hB6AE) begin
      n_fail++; $display("FAIL basic_csum: got %h expected b6ae", {cap_data[10], cap_data[11]});
    end
    n_tests++;
    if ({cap_data[24], cap_data[25]} !== 16'h006C) begin
      n_fail++; $display("FAIL basic_udplen: got %h expected 006c", {cap_data[24], cap_data[25]});
    end
    n_tests++;
    if (hdr_errs(16'd99, exp_id) !== 0) begin
      n_fail++; $display("FAIL basic_hdr: got %0d bad bytes expected 0", hdr_errs(16'd99, exp_id));
    end
    n_tests++;
    if (pay_errs(100) !== 0) begin
      n_fail++; $display("FAIL basic_payload: got %0d bad bytes expected 0", pay_errs(100));
    end
    n_tests++;
    if (last_errs() !== 0) begin
      n_fail++; $display("FAIL basic_tlast: got %0d bad flags expected 0", last_errs());
    end
    next_id();
  endtask

  task automatic test_backpressure();
    run_frame(16'd99, 100, 1'b1, 1'b0, -1);
    n_tests++;
    if (fr_done !== 1'b1 || cap_n !== 128) begin
      n_fail++; $display("FAIL bp_count: got %0d bytes done=%b expected 128 done=1", cap_n, fr_done);
    end
    n_tests++;
    if (lat !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d expected 3", lat); end
    n_tests++;
    if (hdr_errs(16'd99, exp_id) !== 0) begin
      n_fail++; $display("FAIL bp_hdr: got %0d bad bytes expected 0", hdr_errs(16'd99, exp_id));
    end
    n_tests++;
    if (pay_errs(100) !== 0) begin
      n_fail++; $display("FAIL bp_payload: got %0d bad bytes expected 0", pay_errs(100));
    end
    n_tests++;
    if (last_errs() !== 0) begin
      n_fail++; $display("FAIL bp_tlast: got %0d bad flags expected 0", last_errs());
    end
    n_tests++;
    if (stall_err !== 0) begin
      n_fail++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err);
    end
    next_id();
  endtask

  task automatic test_min_len();
    run_frame(16'd0, 1, 1'b0, 1'b0, -1);
    n_tests++;
    if (cap_n !== 29) begin n_fail++; $display("FAIL min_count: got %0d expected 29", cap_n); end
    n_tests++;
    if ({cap_data[2], cap_data[3]} !== 16'h001D) begin
      n_fail++; $display("FAIL min_totlen: got %h expected 001d", {cap_data[2], cap_data[3]});
    end
    n_tests++;
    if ({cap_data[24], cap_data[25]} !== 16'h0009) begin
      n_fail++; $display("FAIL min_udplen: got %h expected 0009", {cap_data[24], cap_data[25]});
    end
    n_tests++;
    if (hdr_errs(16'd0, exp_id) !== 0 || pay_errs(1) !== 0 || last_errs() !== 0) begin
      n_fail++; $display("FAIL min_frame: got hdr=%0d pay=%0d last=%0d expected all 0",
                         hdr_errs(16'd0, exp_id), pay_errs(1), last_errs());
    end
    next_id();
  endtask

  task automatic test_reset_mid_frame();
    run_frame(16'd19, 20, 1'b0, 1'b0, 10);
    @(negedge clk); #1;
    n_tests++;
    if (m_tvalid !== 1'b1 || m_tdata !== model_hdr(16'd19, exp_id, 10)) begin
      n_fail++; $display("FAIL rst_pre: got v=%b d=%h expected v=1 d=%h",
                         m_tvalid, m_tdata, model_hdr(16'd19, exp_id, 10));
    end
    rstn = 1'b0; #1;
    n_tests++;
    if ({m_tvalid, s_tready, len_tready} !== 3'b000 || m_tdata !== 8'h00) begin
      n_fail++; $display("FAIL rst_async: got v=%b sr=%b lr=%b d=%h expected 0 0 0 00",
                         m_tvalid, s_tready, len_tready, m_tdata);
    end
    s_tvalid = 1'b0; len_tvalid = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1; #1;
    n_tests++;
    if (len_tready !== 1'b0 || m_tvalid !== 1'b0) begin
      n_fail++; $display("FAIL rst_release: got lr=%b v=%b expected 0 0", len_tready, m_tvalid);
    end
    exp_id = 16'h0000;
    run_frame(16'd7, 8, 1'b0, 1'b0, -1);
    n_tests++;
    if (cap_data[0] !== 8'h45 || cap_n !== 36) begin
      n_fail++; $display("FAIL rst_clean_start: got first=%h n=%0d expected 45 36", cap_data[0], cap_n);
    end
    n_tests++;
    if (hdr_errs(16'd7, exp_id) !== 0 || pay_errs(8) !== 0) begin
      n_fail++; $display("FAIL rst_clean_frame: got hdr=%0d pay=%0d expected 0 0",
                         hdr_errs(16'd7, exp_id), pay_errs(8));
    end
    next_id();
  endtask

  task automatic test_back_to_back();
    @(negedge clk); rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    exp_id = 16'h0000;
    for (int f = 0; f < 3; f++) begin
      run_frame(16'(f + 2), f + 3, 1'b0, 1'b0, -1);
      n_tests++;
      if ({cap_data[4], cap_data[5]} !== exp_id) begin
        n_fail++; $display("FAIL b2b_id%0d: got %h expected %h", f, {cap_data[4], cap_data[5]}, exp_id);
      end
      n_tests++;
      if (hdr_errs(16'(f + 2), exp_id) !== 0 || cap_n !== 28 + f + 3) begin
        n_fail++; $display("FAIL b2b_frame%0d: got hdr=%0d n=%0d expected 0 %0d",
                           f, hdr_errs(16'(f + 2), exp_id), cap_n, 28 + f + 3);
      end
      next_id();
    end
  endtask

  task automatic test_len_hold();
    for (int f = 0; f < 2; f++) begin
      run_frame(16'd3, 4, 1'b0, 1'b1, -1);
      n_tests++;
      if (len_hs !== 1) begin
        n_fail++; $display("FAIL hold_len_accepts%0d: got %0d expected 1", f, len_hs);
      end
      n_tests++;
      if (bad_idle !== 1'b0) begin
        n_fail++; $display("FAIL hold_len_idle_only%0d: got %b expected 0", f, bad_idle);
      end
      n_tests++;
      if (cap_n !== 32 || hdr_errs(16'd3, exp_id) !== 0) begin
        n_fail++; $display("FAIL hold_len_frame%0d: got n=%0d hdr=%0d expected 32 0",
                           f, cap_n, hdr_errs(16'd3, exp_id));
      end
      next_id();
    end
    @(negedge clk); len_tvalid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_min_len();
    test_reset_mid_frame();
    test_back_to_back();
    test_len_hold();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
